// File: rtl/vram_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// vram_pkg : shared constants and types for the VRAM fill arbiter
// Rev 1.0
// ------------------------------------------------------------------
package vram_pkg;

  localparam logic [15:0] VRAM_BASE  = 16'h0200;
  localparam int          VRAM_WORDS = 1024;
  localparam int          VRAM_AW    = $clog2(VRAM_WORDS);
  localparam logic [15:0] VRAM_END   = VRAM_BASE + 16'(VRAM_WORDS);
  localparam logic [15:0] CTRL_BASE  = 16'h0600;

  localparam logic [2:0] REG_START_LO = 3'd0;
  localparam logic [2:0] REG_START_HI = 3'd1;
  localparam logic [2:0] REG_LEN_LO   = 3'd2;
  localparam logic [2:0] REG_LEN_HI   = 3'd3;
  localparam logic [2:0] REG_VALUE    = 3'd4;
  localparam logic [2:0] REG_CTRL     = 3'd5;

  localparam logic [15:0] CTRL_END = CTRL_BASE + 16'(REG_CTRL);

  typedef enum logic [1:0] {IDLE, FILL, DONE} fill_state_t;

  // Which source drives cpu_rd_data in the cycle after the address.
  typedef enum logic [1:0] {RD_NONE, RD_VRAM, RD_REG} rd_sel_t;

endpackage
`default_nettype wire

// File: rtl/vram_fill_arbiter_if.sv
`default_nettype none
// ------------------------------------------------------------------
// vram_fill_arbiter_if : CPU MMIO bus plus screen RAM port B
// Rev 1.0
// ------------------------------------------------------------------
interface vram_fill_arbiter_if;
  import vram_pkg::*;

  logic [15:0]        addr;
  logic [7:0]         data;
  logic               rw;
  logic [7:0]         cpu_rd_data;
  logic [VRAM_AW-1:0] ram_addr_b;
  logic [7:0]         ram_data_b;
  logic               ram_wren_b;
  logic [7:0]         ram_q_b;

  // master: CPU and RAM side; slave: the arbiter.
  modport master (
    output addr, data, rw, ram_q_b,
    input  cpu_rd_data, ram_addr_b, ram_data_b, ram_wren_b
  );

  modport slave (
    input  addr, data, rw, ram_q_b,
    output cpu_rd_data, ram_addr_b, ram_data_b, ram_wren_b
  );
endinterface
`default_nettype wire

// File: rtl/vram_fill_engine.sv
`default_nettype none
// ------------------------------------------------------------------
// vram_fill_engine : walks a wrapping address run writing one value
// Rev 1.0
// ------------------------------------------------------------------
module vram_fill_engine
  import vram_pkg::*;
(
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               go,
  input  logic               stall,
  input  logic [VRAM_AW-1:0] start,
  input  logic [VRAM_AW-1:0] len,
  input  logic [7:0]         value,
  output logic [VRAM_AW-1:0] addr,
  output logic [7:0]         data,
  output logic               wr_req,
  output logic               busy,
  output logic               done_pulse
);

  localparam logic [VRAM_AW-1:0] PTR_ONE  = 1;
  localparam logic [VRAM_AW:0]   REM_ONE  = 1;
  localparam logic [VRAM_AW:0]   FULL_LEN = (VRAM_AW+1)'(VRAM_WORDS);

  fill_state_t        state_q;
  logic [VRAM_AW-1:0] fill_ptr_q;
  logic [VRAM_AW:0]   remaining_q;
  logic [7:0]         value_q;
  logic               busy_q;
  logic               done_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= IDLE;
      fill_ptr_q  <= '0;
      remaining_q <= '0;
      value_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (go) begin
            state_q     <= FILL;
            fill_ptr_q  <= start;
            // A zero length means the whole screen.
            remaining_q <= (len == '0) ? FULL_LEN : {1'b0, len};
            value_q     <= value;
            busy_q      <= 1'b1;
          end
        end
        FILL: begin
          if (!stall) begin
            fill_ptr_q  <= fill_ptr_q + PTR_ONE;
            remaining_q <= remaining_q - REM_ONE;
            if (remaining_q == REM_ONE) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign addr       = fill_ptr_q;
  assign data       = value_q;
  assign wr_req     = (state_q == FILL);
  assign busy       = busy_q;
  assign done_pulse = done_q;

endmodule
`default_nettype wire

// File: rtl/vram_fill_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// vram_fill_arbiter : shares screen RAM port B between CPU and fill engine
// Rev 1.0
// ------------------------------------------------------------------
module vram_fill_arbiter
  import vram_pkg::*;
(
  input  logic                 CLOCK_50,
  input  logic                 reset,
  vram_fill_arbiter_if.slave   bus,
  output logic                 busy,
  output logic                 done_pulse
);

  logic               cpu_hit;
  logic               reg_hit;
  logic               reg_wr;
  logic               go;
  logic [2:0]         reg_off;

  logic [VRAM_AW-1:0] start_q, start_d;
  logic [VRAM_AW-1:0] len_q, len_d;
  logic [7:0]         value_q, value_d;
  logic               done_sticky_q, done_sticky_d;
  logic [7:0]         reg_rd_q, reg_rd_d;
  rd_sel_t            rd_sel_q, rd_sel_d;

  logic [VRAM_AW-1:0] fill_addr;
  logic [7:0]         fill_data;
  logic               fill_wr;

  assign cpu_hit = (bus.addr >= VRAM_BASE) && (bus.addr < VRAM_END);
  assign reg_hit = (bus.addr >= CTRL_BASE) && (bus.addr <= CTRL_END);
  assign reg_off = 3'(bus.addr - CTRL_BASE);
  assign reg_wr  = reg_hit && !bus.rw;
  assign go      = reg_wr && (reg_off == REG_CTRL) && bus.data[0] && !busy;

  vram_fill_engine u_engine (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .go         (go),
    .stall      (cpu_hit),
    .start      (start_q),
    .len        (len_q),
    .value      (value_q),
    .addr       (fill_addr),
    .data       (fill_data),
    .wr_req     (fill_wr),
    .busy       (busy),
    .done_pulse (done_pulse)
  );

  always_comb begin
    start_d       = start_q;
    len_d         = len_q;
    value_d       = value_q;
    done_sticky_d = go ? 1'b0 : (done_sticky_q | done_pulse);
    if (reg_wr) begin
      case (reg_off)
        REG_START_LO: start_d[7:0] = bus.data;
        REG_START_HI: start_d[9:8] = bus.data[1:0];
        REG_LEN_LO:   len_d[7:0]   = bus.data;
        REG_LEN_HI:   len_d[9:8]   = bus.data[1:0];
        REG_VALUE:    value_d      = bus.data;
        default:      ;
      endcase
    end
  end

  always_comb begin
    reg_rd_d = 8'h00;
    case (reg_off)
      REG_START_LO: reg_rd_d = start_q[7:0];
      REG_START_HI: reg_rd_d = {6'b0, start_q[9:8]};
      REG_LEN_LO:   reg_rd_d = len_q[7:0];
      REG_LEN_HI:   reg_rd_d = {6'b0, len_q[9:8]};
      REG_VALUE:    reg_rd_d = value_q;
      REG_CTRL:     reg_rd_d = {6'b0, done_sticky_q, busy};
      default:      reg_rd_d = 8'h00;
    endcase
    rd_sel_d = RD_NONE;
    if (bus.rw) begin
      if (cpu_hit)      rd_sel_d = RD_VRAM;
      else if (reg_hit) rd_sel_d = RD_REG;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      start_q       <= '0;
      len_q         <= '0;
      value_q       <= '0;
      done_sticky_q <= 1'b0;
      reg_rd_q      <= '0;
      rd_sel_q      <= RD_NONE;
    end else begin
      start_q       <= start_d;
      len_q         <= len_d;
      value_q       <= value_d;
      done_sticky_q <= done_sticky_d;
      reg_rd_q      <= reg_rd_d;
      rd_sel_q      <= rd_sel_d;
    end
  end

  // CPU always owns port B; the engine sees the same decode as its stall.
  always_comb begin
    bus.ram_addr_b = '0;
    bus.ram_data_b = '0;
    bus.ram_wren_b = 1'b0;
    if (!reset) begin
      if (cpu_hit) begin
        bus.ram_addr_b = VRAM_AW'(bus.addr - VRAM_BASE);
        bus.ram_data_b = bus.data;
        bus.ram_wren_b = !bus.rw;
      end else if (fill_wr) begin
        bus.ram_addr_b = fill_addr;
        bus.ram_data_b = fill_data;
        bus.ram_wren_b = 1'b1;
      end
    end
  end

  always_comb begin
    case (rd_sel_q)
      RD_VRAM: bus.cpu_rd_data = bus.ram_q_b;
      RD_REG:  bus.cpu_rd_data = reg_rd_q;
      default: bus.cpu_rd_data = 8'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_vram_fill_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_vram_fill_arbiter : directed self-checking bench with a port-B RAM model
// Rev 1.0
// ------------------------------------------------------------------
module tb_vram_fill_arbiter;
  import vram_pkg::*;

  logic CLOCK_50;
  logic reset;
  logic busy;
  logic done_pulse;

  vram_fill_arbiter_if bus ();

  vram_fill_arbiter dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .bus        (bus),
    .busy       (busy),
    .done_pulse (done_pulse)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [7:0] pat(input int i);
    return 8'(i) ^ 8'hC3;
  endfunction

  logic [7:0] mem  [VRAM_WORDS];
  int         wcnt [VRAM_WORDS];
  logic       mem_init;
  logic       wcnt_clr;

  always @(posedge CLOCK_50) begin
    if (mem_init) begin
      for (int i = 0; i < VRAM_WORDS; i++) begin
        mem[i]  <= pat(i);
        wcnt[i] <= 0;
      end
    end else if (wcnt_clr) begin
      for (int i = 0; i < VRAM_WORDS; i++) wcnt[i] <= 0;
    end else if (bus.ram_wren_b) begin
      mem[bus.ram_addr_b]  <= bus.ram_data_b;
      wcnt[bus.ram_addr_b] <= wcnt[bus.ram_addr_b] + 1;
    end
    bus.ram_q_b <= mem[bus.ram_addr_b];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic idle_bus();
    bus.addr = 16'h0000;
    bus.data = 8'h00;
    bus.rw   = 1'b1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    bus.addr = a;
    bus.data = d;
    bus.rw   = 1'b0;
    tick();
    idle_bus();
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    bus.addr = a;
    bus.rw   = 1'b1;
    tick();
    idle_bus();
    #4;
    d = bus.cpu_rd_data;
  endtask

  task automatic setup_fill(input logic [9:0] s, input logic [9:0] l, input logic [7:0] v);
    cpu_write(16'h0600, s[7:0]);
    cpu_write(16'h0601, {6'b0, s[9:8]});
    cpu_write(16'h0602, l[7:0]);
    cpu_write(16'h0603, {6'b0, l[9:8]});
    cpu_write(16'h0604, v);
  endtask

  // Returns the cycle offset from GO at which done_pulse is seen, or -1.
  task automatic wait_done(input int first, input int limit, output int at);
    int k;
    k  = first;
    at = -1;
    while (k <= limit) begin
      #4;
      if (done_pulse) begin
        at = k;
        break;
      end
      tick();
      k++;
    end
  endtask

  task automatic clear_wcnt();
    wcnt_clr = 1'b1;
    tick();
    wcnt_clr = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    int at;
    int bad;
    int pulses;

    reset    = 1'b1;
    mem_init = 1'b1;
    wcnt_clr = 1'b0;
    idle_bus();
    tick();
    mem_init = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #4;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done_pulse), 0);
    chk("rst_wren", 32'(bus.ram_wren_b), 0);
    chk("rst_rdata", 32'(bus.cpu_rd_data), 0);
    cpu_read(16'h0605, rd);
    chk("rst_status", 32'(rd), 32'h00);

    // Basic 4-word fill with exact cycle timing
    setup_fill(10'h010, 10'd4, 8'h55);
    cpu_read(16'h0602, rd);
    chk("t1_len_lo_rd", 32'(rd), 32'h04);
    cpu_read(16'h0604, rd);
    chk("t1_value_rd", 32'(rd), 32'h55);
    cpu_write(16'h0605, 8'h01);
    for (int k = 1; k <= 4; k++) begin
      #4;
      chk("t1_wren", 32'(bus.ram_wren_b), 1);
      chk("t1_addr", 32'(bus.ram_addr_b), 32'h010 + 32'(k - 1));
      chk("t1_data", 32'(bus.ram_data_b), 32'h55);
      chk("t1_busy", 32'(busy), 1);
      chk("t1_no_done", 32'(done_pulse), 0);
      tick();
    end
    #4;
    chk("t1_done_pulse", 32'(done_pulse), 1);
    chk("t1_busy_done", 32'(busy), 1);
    chk("t1_wren_done", 32'(bus.ram_wren_b), 0);
    tick();
    #4;
    chk("t1_busy_low", 32'(busy), 0);
    chk("t1_done_low", 32'(done_pulse), 0);
    bad = 0;
    for (int a = 16'h010; a <= 16'h013; a++) if (mem[a] !== 8'h55) bad++;
    chk("t1_words", 32'(bad), 0);
    chk("t1_after", 32'(mem[16'h014]), 32'h14 ^ 32'hC3);

    // Wrap around the top of the screen
    setup_fill(10'h3FE, 10'd4, 8'hAA);
    cpu_write(16'h0605, 8'h01);
    wait_done(1, 100, at);
    chk("t2_done_cycle", 32'(at), 5);
    chk("t2_3fe", 32'(mem[10'h3FE]), 32'hAA);
    chk("t2_3ff", 32'(mem[10'h3FF]), 32'hAA);
    chk("t2_000", 32'(mem[10'h000]), 32'hAA);
    chk("t2_001", 32'(mem[10'h001]), 32'hAA);
    chk("t2_002", 32'(mem[10'h002]), 32'hC1);
    chk("t2_3fd", 32'(mem[10'h3FD]), 32'hFD ^ 32'hC3);

    // Status reads, GO while busy, register write while busy
    setup_fill(10'h080, 10'd8, 8'h11);
    cpu_write(16'h0605, 8'h01);
    cpu_read(16'h0605, rd);
    chk("t6_status_busy", 32'(rd), 32'h01);
    cpu_write(16'h0600, 8'h90);
    cpu_write(16'h0605, 8'h01);
    wait_done(4, 100, at);
    chk("t6_done_cycle", 32'(at), 9);
    tick();
    cpu_read(16'h0605, rd);
    chk("t6_status_done", 32'(rd), 32'h02);
    tick();
    tick();
    tick();
    #4;
    chk("t6_no_requeue", 32'(busy), 0);
    cpu_read(16'h0600, rd);
    chk("t6_start_lo_rd", 32'(rd), 32'h90);
    cpu_read(16'h0204, rd);
    chk("t6_vram_rd", 32'(rd), 32'hC7);
    bad = 0;
    for (int a = 16'h080; a <= 16'h087; a++) if (mem[a] !== 8'h11) bad++;
    chk("t6_words", 32'(bad), 0);
    chk("t6_088", 32'(mem[10'h088]), 32'h88 ^ 32'hC3);
    chk("t6_090", 32'(mem[10'h090]), 32'h53);

    // CPU writes to 0x0300 stall the fill on three cycles
    setup_fill(10'h040, 10'd8, 8'h66);
    clear_wcnt();
    cpu_write(16'h0605, 8'h01);
    for (int k = 1; k <= 12; k++) begin
      if (k == 2 || k == 4 || k == 5) begin
        bus.addr = 16'h0300;
        bus.data = 8'(8'h70 + k);
        bus.rw   = 1'b0;
      end else begin
        idle_bus();
      end
      #4;
      if (k == 2 || k == 4 || k == 5) begin
        chk("t4_cpu_addr", 32'(bus.ram_addr_b), 32'h100);
        chk("t4_cpu_data", 32'(bus.ram_data_b), 32'h70 + 32'(k));
      end
      chk("t4_done_timing", 32'(done_pulse), (k == 12) ? 1 : 0);
      tick();
    end
    idle_bus();
    bad = 0;
    for (int a = 16'h040; a <= 16'h047; a++) if (wcnt[a] != 1 || mem[a] !== 8'h66) bad++;
    chk("t4_fill_once", 32'(bad), 0);
    chk("t4_048_untouched", 32'(wcnt[16'h048]), 0);
    chk("t4_cpu_writes", 32'(wcnt[16'h100]), 3);
    chk("t4_cpu_word", 32'(mem[16'h100]), 32'h75);

    // Reset mid-fill, then a fresh full-screen fill from reset registers
    setup_fill(10'h200, 10'd16, 8'h5A);
    cpu_write(16'h0605, 8'h01);
    for (int k = 1; k <= 4; k++) tick();
    reset = 1'b1;
    #4;
    chk("t5_wren_in_rst", 32'(bus.ram_wren_b), 0);
    tick();
    reset = 1'b0;
    #4;
    chk("t5_busy", 32'(busy), 0);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      if (done_pulse) pulses++;
      tick();
      #4;
    end
    chk("t5_no_done", 32'(pulses), 0);
    chk("t5_203", 32'(mem[10'h203]), 32'h5A);
    chk("t5_204", 32'(mem[10'h204]), 32'hC7);
    chk("t5_20f", 32'(mem[10'h20F]), 32'hCC);
    cpu_read(16'h0602, rd);
    chk("t5_len_cleared", 32'(rd), 32'h00);

    clear_wcnt();
    cpu_write(16'h0605, 8'h01);
    wait_done(1, 1100, at);
    chk("t3_done_cycle", 32'(at), 1025);
    bad = 0;
    for (int a = 0; a < VRAM_WORDS; a++) if (mem[a] !== 8'h00 || wcnt[a] != 1) bad++;
    chk("t3_all_zero_once", 32'(bad), 0);
    tick();
    #4;
    chk("t3_busy_low", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
